vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
- Arbitrates one single-port framebuffer RAM between the core's data-memory path (CPU port) and the VGA scan-out engine.
- Keeps a small prefetch FIFO of framebuffer words ahead of the VGA pixel pipeline.
- Gives VGA absolute priority when the FIFO runs low; otherwise CPU accesses get the free slots.
- Sits between the core's memory-mapped framebuffer region and the VGA controller driving RED/GREEN/BLUE/h_sync/v_sync.

Parameters:
- AW, 14, framebuffer word-address width.
- DW, 32, data word width.
- FB_WORDS, 9600, words per frame (640x480 at 1 bpp).
- FIFO_DEPTH, 4, prefetch FIFO entries (power of 2, at least 2).
- LOW_WM, 2, urgency watermark (1 to FIFO_DEPTH-1).

Ports:
- Clock  in  1  single clock, all state on rising edge.
- Rst  in  1  synchronous, active-high reset.
- CpuReq  in  1  CPU access request; held until CpuAck.
- CpuWrEn  in  1  1 = write, 0 = read.
- CpuAddr  in  AW  CPU word address.
- CpuWrData  in  DW  write data.
- CpuAck  out  1  access issued to RAM this cycle.
- CpuRdData  out  DW  read data.
- CpuRdValid  out  1  CpuRdData valid (one cycle after a read ack).
- VgaStart  in  1  frame-start pulse.
- VgaPop  in  1  consume head word.
- VgaData  out  DW  FIFO head word.
- VgaEmpty  out  1  FIFO empty.
- VgaUnderrun  out  1  sticky pop-while-empty flag.
- MemEn  out  1  RAM access enable.
- MemWrEn  out  1  RAM write enable.
- MemAddr  out  AW  RAM address.
- MemWrData  out  DW  RAM write data.
- MemRdData  in  DW  RAM read data, 1-cycle latency after MemEn.

Behaviour:
- Reset (Rst=1 at an edge, including mid-operation): FIFO emptied; in-flight read dropped; fetch pointer=0; fetch disabled.
  - Output values under reset: CpuAck=0, CpuRdValid=0, CpuRdData=0, VgaData=0, VgaEmpty=1, VgaUnderrun=0, MemEn=0, MemWrEn=0.
- Fetch enable: set by VgaStart. Cleared after FB_WORDS VGA reads have been issued in the current frame, or by reset.
- Occupancy: lvl = FIFO count + (1 if a VGA read is in flight).
- Grant, computed combinationally each cycle from registered state, in priority order:
  1. VGA if fetch enabled and lvl < LOW_WM.
  2. Otherwise CPU if CpuReq.
  3. Otherwise VGA if fetch enabled and lvl < FIFO_DEPTH.
  4. Otherwise idle.
- CPU grant:
  - Drives MemEn=1, MemWrEn=CpuWrEn, MemAddr=CpuAddr, MemWrData=CpuWrData, and CpuAck=1 in the same cycle.
  - For a read, CpuRdValid=1 with CpuRdData=MemRdData on the next cycle.
  - Back-to-back CPU accesses are allowed, one per cycle.
- VGA grant:
  - Drives MemEn=1, MemWrEn=0, MemAddr=fetch pointer.
  - Pointer increments, wrapping FB_WORDS-1 -> 0.
  - Read data is pushed into the FIFO on the next cycle.
- Idle cycle: MemEn=0, MemWrEn=0.
- FIFO:
  - VgaData = head word, registered.
  - Push and pop in the same cycle: count unchanged.
  - Overflow is impossible by credit accounting; it is an assertion target.
- VgaPop while VgaEmpty=1: no state change, VgaData holds its value, VgaUnderrun latches 1 until reset or VgaStart.
- VgaStart:
  - Flushes the FIFO, pointer=0, fetch enabled, VgaUnderrun cleared.
  - A VGA read in flight that cycle is discarded (not pushed).
  - A CPU access in the same cycle completes normally.
  - VgaStart and VgaPop together: the flush wins.
- Worst-case CPU latency while fetch is enabled: bounded by the VGA refill burst (at most FIFO_DEPTH cycles) whenever VgaPop rate is at most 1 per 2 cycles.

Test Plan:
- Reset, no VgaStart, CpuReq write addr 0x0010 data 0xA5A5A5A5, then read 0x0010 -> CpuAck same cycle each time; CpuRdValid next cycle with 0xA5A5A5A5; VgaEmpty=1.
- RAM preloaded word[i]=i, VgaStart, no pops -> exactly 4 VGA reads at addresses 0..3; VgaEmpty=0 after 2 cycles; VgaData=0; then MemEn idle.
- FIFO full, CpuReq held, VgaPop every cycle -> VGA wins once lvl<2; CPU is acked within 4 cycles; popped data sequence is 0,1,2,3,4,... with no gaps.
- Fetch through end of frame -> last address issued is 9599; no 9601st read; next VgaStart restarts at address 0.
- VgaPop on empty FIFO -> VgaUnderrun=1 and stays high; next VgaStart clears it to 0.
- Rst asserted with a VGA read in flight and CpuReq high -> next cycle all outputs at reset values; no push into the FIFO; CpuAck=0 until Rst deasserts.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer RAM between CPU accesses and a VGA prefetch FIFO.
// VGA refills take priority below the low watermark; otherwise CPU requests use the free slots.
module vga_fb_arbiter #(
   parameter int AW         = 14,
   parameter int DW         = 32,
   parameter int FB_WORDS   = 9600,
   parameter int FIFO_DEPTH = 4,
   parameter int LOW_WM     = 2
) (
   input  logic          Clock,
   input  logic          Rst,
   input  logic          CpuReq,
   input  logic          CpuWrEn,
   input  logic [AW-1:0] CpuAddr,
   input  logic [DW-1:0] CpuWrData,
   output logic          CpuAck,
   output logic [DW-1:0] CpuRdData,
   output logic          CpuRdValid,
   input  logic          VgaStart,
   input  logic          VgaPop,
   output logic [DW-1:0] VgaData,
   output logic          VgaEmpty,
   output logic          VgaUnderrun,
   output logic          MemEn,
   output logic          MemWrEn,
   output logic [AW-1:0] MemAddr,
   output logic [DW-1:0] MemWrData,
   input  logic [DW-1:0] MemRdData
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int LW = CW + 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(FB_WORDS - 1);
   localparam logic [LW-1:0] LOW_LVL   = LW'(LOW_WM);
   localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
   localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {GNT_IDLE, GNT_CPU, GNT_VGA} grant_t;

   grant_t          gnt;
   logic            fetch_en;
   logic [AW-1:0]   fetch_ptr;
   logic            vga_rd_vld_p1;
   logic            cpu_rd_vld_p1;
   logic [DW-1:0]   fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [DW-1:0]   head_q;
   logic            underrun_q;

   logic [LW-1:0]   lvl;
   logic            push;
   logic            pop;
   logic [CW-1:0]   cnt_after_pop;
   logic [CW-1:0]   cnt_nxt;
   logic [PW-1:0]   rd_ptr_nxt;
   logic [DW-1:0]   head_nxt;

   // Occupancy counts the outstanding VGA read so refills never exceed FIFO capacity.
   assign lvl = LW'(count) + LW'(vga_rd_vld_p1);

   always_comb begin
      gnt = GNT_IDLE;
      if (!Rst) begin
         if (fetch_en && (lvl < LOW_LVL))
            gnt = GNT_VGA;
         else if (CpuReq)
            gnt = GNT_CPU;
         else if (fetch_en && (lvl < FULL_LVL))
            gnt = GNT_VGA;
      end
   end

   assign MemEn     = (gnt != GNT_IDLE);
   assign MemWrEn   = (gnt == GNT_CPU) && CpuWrEn;
   assign MemAddr   = (gnt == GNT_CPU) ? CpuAddr : fetch_ptr;
   assign MemWrData = CpuWrData;
   assign CpuAck    = (gnt == GNT_CPU);

   assign CpuRdValid  = cpu_rd_vld_p1;
   assign CpuRdData   = cpu_rd_vld_p1 ? MemRdData : '0;
   assign VgaData     = head_q;
   assign VgaEmpty    = (count == '0);
   assign VgaUnderrun = underrun_q;

   // A frame restart discards the read returning this cycle; popping an empty FIFO does nothing.
   assign push = vga_rd_vld_p1 && !VgaStart;
   assign pop  = VgaPop && (count != '0) && !VgaStart;

   always_comb begin
      cnt_after_pop = count - CW'(pop);
      cnt_nxt       = cnt_after_pop + CW'(push);
      rd_ptr_nxt    = rd_ptr + PW'(pop);
      head_nxt      = head_q;
      if (cnt_nxt != '0)
         head_nxt = (cnt_after_pop == '0) ? MemRdData : fifo_mem[rd_ptr_nxt];
   end

   // ---- stage p1: RAM returns data for the previous cycle's grant ----
   always_ff @(posedge Clock) begin
      if (Rst) begin
         fetch_en      <= 1'b0;
         fetch_ptr     <= '0;
         vga_rd_vld_p1 <= 1'b0;
         cpu_rd_vld_p1 <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         underrun_q    <= 1'b0;
         head_q        <= '0;
      end else begin
         cpu_rd_vld_p1 <= (gnt == GNT_CPU) && !CpuWrEn;
         if (VgaStart) begin
            fetch_en      <= 1'b1;
            fetch_ptr     <= '0;
            vga_rd_vld_p1 <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            underrun_q    <= 1'b0;
         end else begin
            vga_rd_vld_p1 <= (gnt == GNT_VGA);
            if (gnt == GNT_VGA) begin
               if (fetch_ptr == LAST_ADDR) begin
                  fetch_ptr <= '0;
                  fetch_en  <= 1'b0;
               end else begin
                  fetch_ptr <= fetch_ptr + AW'(1);
               end
            end
            if (push)
               wr_ptr <= wr_ptr + PW'(1);
            rd_ptr <= rd_ptr_nxt;
            count  <= cnt_nxt;
            head_q <= head_nxt;
            if (VgaPop && (count == '0))
               underrun_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (push)
         fifo_mem[wr_ptr] <= MemRdData;
   end

   always_ff @(posedge Clock) begin
      if (!Rst)
         assert (!(push && !pop && (count == FULL_CNT)));
   end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: vector table for the basic cycles, then
// a modelled full-frame fetch, end-of-frame, restart and reset-with-read-in-flight.
module tb_vga_fb_arbiter;

   localparam int AW       = 14;
   localparam int DW       = 32;
   localparam int FB_WORDS = 9600;
   localparam int NV       = 23;

   logic          Clock = 1'b0;
   logic          Rst;
   logic          CpuReq;
   logic          CpuWrEn;
   logic [AW-1:0] CpuAddr;
   logic [DW-1:0] CpuWrData;
   logic          CpuAck;
   logic [DW-1:0] CpuRdData;
   logic          CpuRdValid;
   logic          VgaStart;
   logic          VgaPop;
   logic [DW-1:0] VgaData;
   logic          VgaEmpty;
   logic          VgaUnderrun;
   logic          MemEn;
   logic          MemWrEn;
   logic [AW-1:0] MemAddr;
   logic [DW-1:0] MemWrData;
   logic [DW-1:0] MemRdData;

   int total = 0;
   int bad   = 0;

   always #5 Clock = ~Clock;

   vga_fb_arbiter dut (
      .Clock(Clock), .Rst(Rst),
      .CpuReq(CpuReq), .CpuWrEn(CpuWrEn), .CpuAddr(CpuAddr), .CpuWrData(CpuWrData),
      .CpuAck(CpuAck), .CpuRdData(CpuRdData), .CpuRdValid(CpuRdValid),
      .VgaStart(VgaStart), .VgaPop(VgaPop), .VgaData(VgaData),
      .VgaEmpty(VgaEmpty), .VgaUnderrun(VgaUnderrun),
      .MemEn(MemEn), .MemWrEn(MemWrEn), .MemAddr(MemAddr), .MemWrData(MemWrData),
      .MemRdData(MemRdData)
   );

   // RAM model: word[i] = i until written, 1-cycle read latency.
   bit   [DW-1:0] ram    [0:(1<<AW)-1];
   bit            ram_ok [0:(1<<AW)-1];
   logic [DW-1:0] rd_q;
   assign MemRdData = rd_q;

   always @(posedge Clock) begin
      if (MemEn) begin
         if (MemWrEn) begin
            ram[MemAddr]    <= MemWrData;
            ram_ok[MemAddr] <= 1'b1;
         end else begin
            rd_q <= ram_ok[MemAddr] ? ram[MemAddr] : DW'(MemAddr);
         end
      end
   end

   typedef struct {
      logic          rst, req, wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          start, pop;
      logic          e_ack, e_men, e_mwr;
      logic [AW-1:0] e_maddr;
      logic          e_rv;
      logic [DW-1:0] e_rd;
      logic          e_empty, e_unr, chk_vd;
      logic [DW-1:0] e_vd;
   } vec_t;

   vec_t vt [NV];

   function automatic vec_t mk(input int rst, input int req, input int wr, input int addr,
                               input int wdata, input int start, input int pop,
                               input int ack, input int men, input int mwr, input int maddr,
                               input int rv, input int rd, input int empty, input int unr,
                               input int chkvd, input int vd);
      vec_t m;
      m.rst = rst[0];  m.req = req[0];  m.wr = wr[0];
      m.addr = AW'(addr);  m.wdata = DW'(wdata);
      m.start = start[0];  m.pop = pop[0];
      m.e_ack = ack[0];  m.e_men = men[0];  m.e_mwr = mwr[0];
      m.e_maddr = AW'(maddr);  m.e_rv = rv[0];  m.e_rd = DW'(rd);
      m.e_empty = empty[0];  m.e_unr = unr[0];  m.chk_vd = chkvd[0];  m.e_vd = DW'(vd);
      return m;
   endfunction

   function automatic logic [DW-1:0] expw(input int i);
      return (i == 16) ? 32'hA5A5A5A5 : DW'(i);
   endfunction

   task automatic chk1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0b want=%0b", nm, act, exp);
      end
   endtask

   task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   int   issued, popped, dut_reads, last_addr, age, gap, cyc, extra, lvl;
   logic prev_rd, fen, exp_vga, exp_cpu, pop_now, ack_seen;
   logic [AW-1:0] prev_addr;

   initial begin
      //           rst req wr addr  wdata        st pop | ack men mwr maddr rv rd           emp unr cv vd
      vt[0]  = mk(1, 1, 1, 'h10, 'hA5A5A5A5,   0, 0,   0, 0, 0, 0,    0, 0,           1, 0, 1, 0);
      vt[1]  = mk(0, 1, 1, 'h10, 'hA5A5A5A5,   0, 0,   1, 1, 1, 'h10, 0, 0,           1, 0, 1, 0);
      vt[2]  = mk(0, 1, 0, 'h10, 0,            0, 0,   1, 1, 0, 'h10, 0, 0,           1, 0, 1, 0);
      vt[3]  = mk(0, 0, 0, 0,    0,            0, 0,   0, 0, 0, 0,    1, 'hA5A5A5A5,  1, 0, 1, 0);
      vt[4]  = mk(0, 0, 0, 0,    0,            0, 0,   0, 0, 0, 0,    0, 0,           1, 0, 1, 0);
      vt[5]  = mk(0, 0, 0, 0,    0,            0, 1,   0, 0, 0, 0,    0, 0,           1, 0, 1, 0);
      vt[6]  = mk(0, 0, 0, 0,    0,            0, 0,   0, 0, 0, 0,    0, 0,           1, 1, 1, 0);
      vt[7]  = mk(0, 0, 0, 0,    0,            1, 0,   0, 0, 0, 0,    0, 0,           1, 1, 1, 0);
      vt[8]  = mk(0, 0, 0, 0,    0,            0, 0,   0, 1, 0, 0,    0, 0,           1, 0, 1, 0);
      vt[9]  = mk(0, 0, 0, 0,    0,            0, 0,   0, 1, 0, 1,    0, 0,           1, 0, 1, 0);
      vt[10] = mk(0, 0, 0, 0,    0,            0, 0,   0, 1, 0, 2,    0, 0,           0, 0, 1, 0);
      vt[11] = mk(0, 0, 0, 0,    0,            0, 0,   0, 1, 0, 3,    0, 0,           0, 0, 1, 0);
      vt[12] = mk(0, 0, 0, 0,    0,            0, 0,   0, 0, 0, 0,    0, 0,           0, 0, 1, 0);
      vt[13] = mk(0, 0, 0, 0,    0,            0, 0,   0, 0, 0, 0,    0, 0,           0, 0, 1, 0);
      vt[14] = mk(0, 1, 0, 5,    0,            0, 0,   1, 1, 0, 5,    0, 0,           0, 0, 1, 0);
      vt[15] = mk(0, 0, 0, 0,    0,            0, 0,   0, 0, 0, 0,    1, 5,           0, 0, 1, 0);
      vt[16] = mk(0, 0, 0, 0,    0,            0, 1,   0, 0, 0, 0,    0, 0,           0, 0, 1, 0);
      vt[17] = mk(0, 0, 0, 0,    0,            0, 0,   0, 1, 0, 4,    0, 0,           0, 0, 1, 1);
      vt[18] = mk(0, 0, 0, 0,    0,            0, 0,   0, 0, 0, 0,    0, 0,           0, 0, 1, 1);
      vt[19] = mk(0, 0, 0, 0,    0,            1, 1,   0, 0, 0, 0,    0, 0,           0, 0, 1, 1);
      vt[20] = mk(0, 0, 0, 0,    0,            0, 0,   0, 1, 0, 0,    0, 0,           1, 0, 0, 0);
      vt[21] = mk(0, 0, 0, 0,    0,            0, 0,   0, 1, 0, 1,    0, 0,           1, 0, 0, 0);
      vt[22] = mk(0, 0, 0, 0,    0,            0, 0,   0, 1, 0, 2,    0, 0,           0, 0, 1, 0);

      Rst = 1'b1; CpuReq = 1'b0; CpuWrEn = 1'b0; CpuAddr = '0; CpuWrData = '0;
      VgaStart = 1'b0; VgaPop = 1'b0;
      tick();
      tick();

      for (int i = 0; i < NV; i++) begin
         Rst = vt[i].rst; CpuReq = vt[i].req; CpuWrEn = vt[i].wr; CpuAddr = vt[i].addr;
         CpuWrData = vt[i].wdata; VgaStart = vt[i].start; VgaPop = vt[i].pop;
         #1;
         chk1($sformatf("r%0d_ack", i), CpuAck, vt[i].e_ack);
         chk1($sformatf("r%0d_men", i), MemEn, vt[i].e_men);
         chk1($sformatf("r%0d_mwr", i), MemWrEn, vt[i].e_mwr);
         if (vt[i].e_men)
            chkw($sformatf("r%0d_maddr", i), DW'(MemAddr), DW'(vt[i].e_maddr));
         chk1($sformatf("r%0d_rdvalid", i), CpuRdValid, vt[i].e_rv);
         chkw($sformatf("r%0d_rddata", i), CpuRdData, vt[i].e_rd);
         chk1($sformatf("r%0d_empty", i), VgaEmpty, vt[i].e_empty);
         chk1($sformatf("r%0d_underrun", i), VgaUnderrun, vt[i].e_unr);
         if (vt[i].chk_vd)
            chkw($sformatf("r%0d_vgadata", i), VgaData, vt[i].e_vd);
         tick();
      end

      // Full frame: pops every cycle at first, then every other cycle, with periodic CPU reads.
      CpuReq = 1'b0; VgaPop = 1'b0; VgaStart = 1'b1;
      tick();
      VgaStart = 1'b0;
      issued = 0; popped = 0; dut_reads = 0; last_addr = -1; gap = 3; age = 0;
      prev_rd = 1'b0; prev_addr = '0; cyc = 0;
      while ((issued < FB_WORDS || popped < FB_WORDS) && cyc < 40000) begin
         pop_now = !VgaEmpty && (cyc < 200 || (cyc % 2) == 0);
         if (!CpuReq) begin
            if (gap > 0) gap--;
            else begin
               CpuReq = 1'b1; CpuWrEn = 1'b0; CpuAddr = AW'(100 + (cyc % 50)); age = 0;
            end
         end
         VgaPop = pop_now;
         #1;
         lvl     = issued - popped;
         fen     = (issued < FB_WORDS);
         exp_vga = fen && ((lvl < 2) || (!CpuReq && lvl < 4));
         exp_cpu = CpuReq && !exp_vga;
         chk1("grant_cpu", CpuAck, exp_cpu);
         chk1("grant_men", MemEn, exp_vga || exp_cpu);
         chk1("grant_mwr", MemWrEn, 1'b0);
         if (exp_vga) chkw("vga_addr", DW'(MemAddr), DW'(issued));
         if (exp_cpu) chkw("cpu_addr", DW'(MemAddr), DW'(CpuAddr));
         chk1("cpu_rdvalid", CpuRdValid, prev_rd);
         if (prev_rd) chkw("cpu_rddata", CpuRdData, expw(int'(prev_addr)));
         if (pop_now) chkw("pop_data", VgaData, expw(popped));
         if (MemEn && !CpuAck) begin
            dut_reads++;
            last_addr = int'(MemAddr);
         end
         prev_rd   = exp_cpu;
         prev_addr = CpuAddr;
         if (exp_vga) issued++;
         if (pop_now) popped++;
         ack_seen = CpuReq && CpuAck;
         if (ack_seen) chki("cpu_latency_lt4", int'(age < 4), 1);
         tick();
         if (ack_seen) begin
            CpuReq = 1'b0; gap = 2;
         end else if (CpuReq) begin
            age++;
            if (age > 12) begin
               chki("cpu_ack_timeout", age, 0);
               CpuReq = 1'b0; gap = 2;
            end
         end
         cyc++;
      end
      chki("frame_finished_in_budget", int'(cyc < 40000), 1);
      chki("frame_vga_reads", dut_reads, FB_WORDS);
      chki("frame_last_addr", last_addr, FB_WORDS - 1);
      chki("frame_words_popped", popped, FB_WORDS);

      CpuReq = 1'b0; VgaPop = 1'b0;
      extra = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (MemEn) extra++;
         tick();
      end
      chki("no_read_after_frame", extra, 0);

      // Restart goes back to address 0.
      VgaStart = 1'b1;
      tick();
      VgaStart = 1'b0;
      #1;
      chk1("restart_men", MemEn, 1'b1);
      chkw("restart_addr", DW'(MemAddr), 32'd0);
      tick();

      // Reset with a VGA read in flight and a CPU request pending.
      Rst = 1'b1; CpuReq = 1'b1; CpuWrEn = 1'b0; CpuAddr = AW'(7);
      #1;
      chk1("rst_in_ack", CpuAck, 1'b0);
      chk1("rst_in_men", MemEn, 1'b0);
      tick();
      chk1("rst_ack", CpuAck, 1'b0);
      chk1("rst_men", MemEn, 1'b0);
      chk1("rst_mwr", MemWrEn, 1'b0);
      chk1("rst_rdvalid", CpuRdValid, 1'b0);
      chkw("rst_rddata", CpuRdData, 32'd0);
      chk1("rst_empty", VgaEmpty, 1'b1);
      chk1("rst_underrun", VgaUnderrun, 1'b0);
      chkw("rst_vgadata", VgaData, 32'd0);
      tick();
      chk1("rst_hold_ack", CpuAck, 1'b0);
      chk1("rst_hold_empty", VgaEmpty, 1'b1);
      Rst = 1'b0;
      #1;
      chk1("post_rst_ack", CpuAck, 1'b1);
      chkw("post_rst_addr", DW'(MemAddr), 32'd7);
      tick();
      CpuReq = 1'b0;
      #1;
      chk1("post_rst_rdvalid", CpuRdValid, 1'b1);
      chkw("post_rst_rddata", CpuRdData, 32'd7);
      chk1("post_rst_idle", MemEn, 1'b0);
      chk1("post_rst_empty", VgaEmpty, 1'b1);
      tick();
      chk1("post_rst_idle2", MemEn, 1'b0);
      chk1("post_rst_empty2", VgaEmpty, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
